// File: rtl/tp1_btn_debounce.sv
// Push-button conditioner: per-channel synchroniser, stable-time debounce FSM,
// and registered clean level plus a single-cycle press strobe.
module tp1_btn_debounce #(
    parameter int NB_BTN          = 3,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NB_SYNC         = 2
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic [NB_BTN-1:0] i_buttons,
    output logic [NB_BTN-1:0] o_btn_level,
    output logic [NB_BTN-1:0] o_btn_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHK_PRESS = 2'd1,
        PRESSED   = 2'd2,
        CHK_REL   = 2'd3
    } state_t;

    logic [NB_BTN-1:0] sync_q [NB_SYNC];
    logic [NB_BTN-1:0] sync_d [NB_SYNC];
    logic [NB_BTN-1:0] btn_s;

    always_comb begin
        sync_d[0] = i_buttons;
        for (int i = 1; i < NB_SYNC; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NB_SYNC; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_SYNC; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign btn_s = sync_q[NB_SYNC-1];

    for (genvar k = 0; k < NB_BTN; k++) begin : g_chan
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             pulse_q, pulse_d;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: begin
                    if (btn_s[k]) begin
                        state_d = CHK_PRESS;
                        cnt_d   = '0;
                    end
                end
                CHK_PRESS: begin
                    if (!btn_s[k]) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_s[k]) begin
                        state_d = CHK_REL;
                        cnt_d   = '0;
                    end
                end
                CHK_REL: begin
                    if (btn_s[k]) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
            // Outputs decode the next state so they change on the same edge as the FSM.
            level_d = (state_d == PRESSED) || (state_d == CHK_REL);
            pulse_d = (state_d == PRESSED) && (state_q == CHK_PRESS);
        end

        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                pulse_q <= pulse_d;
            end
        end

        assign o_btn_level[k] = level_q;
        assign o_btn_pulse[k] = pulse_q;
    end

endmodule

// File: tb/tb_tp1_btn_debounce.sv
// Bench for tp1_btn_debounce: directed button scenarios plus random bouncing,
// checked against a run-length debounce model and a pulse scoreboard.
module tb_tp1_btn_debounce;

    localparam int NB   = 3;
    localparam int DB   = 4;
    localparam int NS   = 2;
    localparam int HALF = 5;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] btn;
    logic [NB-1:0] level;
    logic [NB-1:0] pulse;

    int errors = 0;
    int checks = 0;

    tp1_btn_debounce #(
        .NB_BTN(NB),
        .DEBOUNCE_CYCLES(DB),
        .NB_SYNC(NS)
    ) dut (
        .i_clock(clk),
        .i_reset_n(rst_n),
        .i_buttons(btn),
        .o_btn_level(level),
        .o_btn_pulse(pulse)
    );

    // clock / reset
    initial clk = 1'b0;
    always #HALF clk = ~clk;

    // reference model: a button level flips once the synchronised input has
    // disagreed with it on DB+1 consecutive sampling edges
    logic [NB-1:0] m_level;
    logic [NB-1:0] m_hist [NS];
    int            m_run  [NB];
    logic [NB-1:0] exp_q   [$];
    time           exp_t_q [$];

    always @(posedge clk or negedge rst_n) begin
        logic [NB-1:0] s;
        logic [NB-1:0] rise;
        if (!rst_n) begin
            m_level = '0;
            for (int k = 0; k < NB; k++) m_run[k] = 0;
            for (int i = 0; i < NS; i++) m_hist[i] = '0;
        end else begin
            s = m_hist[NS-1];
            for (int i = NS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = btn;
            rise = '0;
            for (int k = 0; k < NB; k++) begin
                if (s[k] != m_level[k]) begin
                    m_run[k] = m_run[k] + 1;
                    if (m_run[k] == DB + 1) begin
                        m_level[k] = s[k];
                        m_run[k]   = 0;
                        if (s[k]) rise[k] = 1'b1;
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            if (rise != '0) begin
                exp_q.push_back(rise);
                exp_t_q.push_back($time);
            end
        end
    end

    // scoreboard monitor
    logic mon_en = 1'b0;
    int   pcnt [NB];
    int   both_seen = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_t_q.size() > 0 && exp_t_q[0] < $time - HALF) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse: expected pulse %b at t=%0t not seen (now t=%0t)",
                         exp_q[0], exp_t_q[0], $time);
                void'(exp_q.pop_front());
                void'(exp_t_q.pop_front());
            end
            checks++;
            if (level !== m_level) begin
                errors++;
                $display("FAIL level: t=%0t got %b expected %b", $time, level, m_level);
            end
            if (pulse !== '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: t=%0t got %b expected none", $time, pulse);
                end else begin
                    if (pulse !== exp_q[0] || exp_t_q[0] != $time - HALF) begin
                        errors++;
                        $display("FAIL pulse: t=%0t got %b expected %b at edge t=%0t",
                                 $time, pulse, exp_q[0], exp_t_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(exp_t_q.pop_front());
                end
                for (int k = 0; k < NB; k++) if (pulse[k] === 1'b1) pcnt[k]++;
                if (pulse === 3'b101) both_seen++;
            end
        end
    end

    // driver tasks
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NB; k++) pcnt[k] = 0;
        both_seen = 0;
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [NB-1:0] got, input logic [NB-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    initial begin
        int hold [NB];
        rst_n = 1'b0;
        btn   = '0;
        for (int k = 0; k < NB; k++) pcnt[k] = 0;
        step(3);
        check_vec("reset_level", level, '0);
        check_vec("reset_pulse", pulse, '0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        step(2);

        // 1: single steady press and release on channel 2
        clear_counts();
        btn = 3'b100;
        step(20);
        btn = 3'b000;
        step(12);
        check_int("t1_pulse2", pcnt[2], 1);
        check_int("t1_pulse0", pcnt[0], 0);
        check_int("t1_pulse1", pcnt[1], 0);
        step($urandom_range(1, 5));

        // 2: bouncing press on channel 0
        clear_counts();
        repeat (5) begin
            btn[0] = 1'b1;
            step(3);
            btn[0] = 1'b0;
            step(1);
        end
        btn[0] = 1'b1;
        step(20);
        btn[0] = 1'b0;
        step(12);
        check_int("t2_pulse0", pcnt[0], 1);

        // 3: glitch shorter than the debounce window
        clear_counts();
        btn[1] = 1'b1;
        step(3);
        btn[1] = 1'b0;
        step(12);
        check_int("t3_pulse1", pcnt[1], 0);

        // 4: simultaneous press on channels 0 and 2
        clear_counts();
        btn = 3'b101;
        step(20);
        check_int("t4_pulse0", pcnt[0], 1);
        check_int("t4_pulse2", pcnt[2], 1);
        check_int("t4_same_cycle", both_seen, 1);
        btn = 3'b000;
        step(12);

        // 5: reset mid-count, button held through reset release
        clear_counts();
        btn = 3'b100;
        step(6);
        rst_n = 1'b0;
        #1;
        check_vec("t5_rst_level", level, '0);
        check_vec("t5_rst_pulse", pulse, '0);
        step(3);
        rst_n = 1'b1;
        step(20);
        check_int("t5_pulse2", pcnt[2], 1);
        btn = 3'b000;
        step(12);

        // 6: short low dip while pressed
        clear_counts();
        btn[0] = 1'b1;
        step(12);
        btn[0] = 1'b0;
        step(2);
        btn[0] = 1'b1;
        step(10);
        check_int("t6_pulse0", pcnt[0], 1);
        check_vec("t6_level", level, 3'b001);
        btn[0] = 1'b0;
        step(12);

        // random bouncing on all channels
        for (int k = 0; k < NB; k++) hold[k] = 0;
        repeat (400) begin
            for (int k = 0; k < NB; k++) begin
                if (hold[k] == 0) begin
                    btn[k]  = 1'($urandom_range(0, 1));
                    hold[k] = int'($urandom_range(1, 9));
                end else begin
                    hold[k]--;
                end
            end
            step(1);
        end
        btn = '0;
        step(15);
        check_int("pending_pulses", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
